ex_muldiv_unit: RTL

Parametrised multi-cycle RV32M/RV64M multiply/divide unit in the execute stage, alongside the single-cycle ALU. It takes already-forwarded rs1/rs2 values, runs an iterative shift-add multiply or restoring divide, and stalls the upstream pipeline until the result is ready. It produces one registered result pulse with its destination label for the EX/MEM register.

---
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Iterative shift-add multiply and restoring divide; stalls the front end until the result retires.
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_label_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_label_o
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [XLEN-1:0] abs_word(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // For divides, v holds {remainder, quotient} as magnitudes.
    function automatic logic [XLEN-1:0] select_result(input logic [2:0] f,
                                                      input logic [2*XLEN-1:0] v,
                                                      input logic neg_main,
                                                      input logic neg_rem);
        logic [2*XLEN-1:0] p;
        if (!f[2]) begin
            p = fix_wide(v, neg_main);
            return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        return f[1] ? abs_word(v[2*XLEN-1:XLEN], neg_rem) : abs_word(v[XLEN-1:0], neg_main);
    endfunction

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [4:0]        label;
    logic              neg_main;
    logic              neg_rem;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;

    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     trial;

    always_comb begin
        is_div      = funct3_i[2];
        sgn_a       = rs1_i[XLEN-1] & (is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
        sgn_b       = rs2_i[XLEN-1] & (is_div ? ~funct3_i[0] : ~funct3_i[1]);
        mag_a       = abs_word(rs1_i, sgn_a);
        mag_b       = abs_word(rs2_i, sgn_b);
        div_zero    = is_div & (rs2_i == '0);
        div_ovf     = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
        fast_prod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        special     = is_div ? (div_zero | div_ovf) : FAST_MUL;
        if (div_zero)
            special_res = funct3_i[1] ? rs1_i : '1;
        else if (div_ovf)
            special_res = funct3_i[1] ? '0 : rs1_i;
        else
            special_res = select_result(funct3_i, fast_prod, sgn_a ^ sgn_b, 1'b0);
    end

    // Divide step: shift {rem, dividend} left, keep the subtraction only if it does not borrow.
    always_comb begin
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
        if (state == S_DIV)
            acc_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = acc + (opb[0] ? mcand : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            count      <= '0;
            op         <= '0;
            label      <= '0;
            neg_main   <= 1'b0;
            neg_rem    <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            opb        <= '0;
            result_o   <= '0;
            rd_label_o <= '0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        op       <= funct3_i;
                        label    <= rd_label_i;
                        neg_main <= sgn_a ^ sgn_b;
                        neg_rem  <= sgn_a;
                        count    <= CW'(XLEN);
                        if (special) begin
                            result_o   <= special_res;
                            rd_label_o <= rd_label_i;
                            state      <= S_DONE;
                        end else if (is_div) begin
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            opb   <= mag_b;
                            state <= S_DIV;
                        end else begin
                            acc   <= '0;
                            mcand <= {{XLEN{1'b0}}, mag_a};
                            opb   <= mag_b;
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    opb   <= (state == S_MUL) ? (opb >> 1) : opb;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result_o   <= select_result(op, acc_next, neg_main, neg_rem);
                        rd_label_o <= label;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall_o        = rst_ni & ~flush_i &
                            (((state == S_IDLE) & valid_i) | (state == S_MUL) | (state == S_DIV));
    assign busy_o         = (state != S_IDLE);
    assign result_valid_o = (state == S_DONE) & ~flush_i;

endmodule
